// File: rtl/fib_if.sv
// Handshake/bus bundle between the Fibonacci controller (master) and the
// datapath (slave).
interface fib_if #(
    parameter int WIDTH = 16
);
    logic             wren;
    logic [11:0]      address;
    logic [1:0]       stage;
    logic             result_ack;
    logic [WIDTH-1:0] result;
    logic             result_valid;
    logic             overflow;
    logic             range_err;

    modport master (
        output wren, address, stage, result_ack,
        input  result, result_valid, overflow, range_err
    );

    modport slave (
        input  wren, address, stage, result_ack,
        output result, result_valid, overflow, range_err
    );
endinterface

// File: rtl/fib_datapath.sv
// Memory-and-adder datapath for the Fibonacci controller: seeds the table,
// latches operands, writes sums and returns table entries on a valid/ack handshake.
module fib_datapath #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 64
) (
    input logic  CLK,
    input logic  reset,
    fib_if.slave bus
);
    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [12:0] DEPTH_L = 13'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             evt_d;

    logic             in_range;
    logic [AW-1:0]    idx;
    logic [WIDTH-1:0] rd;
    logic             seed;
    logic             lda;
    logic             ldb;
    logic             wsum;
    logic             zero_wr;
    logic             evt;
    logic             access;
    logic             cap;
    logic             mem_we;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] value;
    logic [WIDTH-1:0] wdata;

    always_comb begin
        in_range = {1'b0, bus.address} < DEPTH_L;
        idx      = bus.address[AW-1:0];
        rd       = in_range ? mem[idx] : '0;

        seed    = (bus.stage == 2'b00) && bus.wren;
        lda     = (bus.stage == 2'b01);
        ldb     = (bus.stage == 2'b10);
        wsum    = (bus.stage == 2'b11) && bus.wren && (bus.address != 12'd0);
        zero_wr = (bus.stage == 2'b11) && bus.wren && (bus.address == 12'd0);
        evt     = (bus.stage == 2'b11) && (!bus.wren || (bus.address == 12'd0));
        access  = seed || lda || ldb || wsum || evt;

        sum   = {1'b0, opA} + {1'b0, opB};
        value = zero_wr ? '0 : rd;

        // Writes are held off during reset so an abandoned sum never lands.
        mem_we = !reset && in_range && (seed || wsum || zero_wr);
        wdata  = '0;
        if (wsum) begin
            wdata = sum[WIDTH-1:0];
        end else if (seed && (bus.address == 12'd1)) begin
            wdata = {{(WIDTH-1){1'b0}}, 1'b1};
        end

        cap = evt && !evt_d && (!bus.result_valid || bus.result_ack);
    end

    // Table is intentionally not reset; seeding rewrites it.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[idx] <= wdata;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            opA              <= '0;
            opB              <= '0;
            evt_d            <= 1'b0;
            bus.result       <= '0;
            bus.result_valid <= 1'b0;
            bus.overflow     <= 1'b0;
            bus.range_err    <= 1'b0;
        end else begin
            if (lda) begin
                opA <= rd;
            end
            if (ldb) begin
                opB <= rd;
            end
            evt_d <= evt;
            if (wsum && in_range && sum[WIDTH]) begin
                bus.overflow <= 1'b1;
            end
            if (access && !in_range) begin
                bus.range_err <= 1'b1;
            end
            if (cap) begin
                bus.result       <= value;
                bus.result_valid <= 1'b1;
            end else if (bus.result_ack) begin
                bus.result_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fib_datapath.sv
// Directed bench for fib_datapath: expected results are queued at issue time and
// checked by a monitor when each result is accepted.
module tb_fib_datapath;
    localparam int WIDTH = 16;
    localparam int DEPTH = 64;

    logic CLK = 1'b0;
    logic reset;

    fib_if #(.WIDTH(WIDTH)) bus ();

    fib_datapath #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .CLK  (CLK),
        .reset(reset),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    int               n_tests = 0;
    int               n_fail  = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] mon_exp;

    // Monitor: every accepted result must match the head of the queue.
    always @(negedge CLK) begin
        if (!reset && bus.result_valid && bus.result_ack) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL result_accept: got unexpected result %0d, required none", bus.result);
            end else begin
                mon_exp = exp_q.pop_front();
                if (bus.result !== mon_exp) begin
                    n_fail++;
                    $display("FAIL result_accept: got %0d, required %0d", bus.result, mon_exp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Present one cycle of controller inputs; returns #1 after the sampling edge.
    task automatic put(input logic [1:0] st, input logic w, input int a);
        bus.stage   = st;
        bus.wren    = w;
        bus.address = 12'(a);
        @(posedge CLK);
        #1;
    endtask

    task automatic query(input int a, input int exp);
        exp_q.push_back(WIDTH'(exp));
        put(2'b11, 1'b0, a);
        chk("query_valid", 32'(bus.result_valid), 1);
        bus.result_ack = 1'b1;
        put(2'b00, 1'b0, 0);
        bus.result_ack = 1'b0;
    endtask

    task automatic step(input int n);
        put(2'b01, 1'b0, n - 2);
        put(2'b10, 1'b0, n - 1);
        put(2'b11, 1'b1, n);
    endtask

    initial begin
        reset          = 1'b1;
        bus.wren       = 1'b0;
        bus.address    = '0;
        bus.stage      = '0;
        bus.result_ack = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_result", 32'(bus.result), 0);
        chk("reset_valid", 32'(bus.result_valid), 0);
        chk("reset_overflow", 32'(bus.overflow), 0);
        chk("reset_range_err", 32'(bus.range_err), 0);
        reset = 1'b0;

        // Seed, then a sustained query yields exactly one capture.
        for (int a = 0; a < 4; a++) put(2'b00, 1'b1, a);
        exp_q.push_back(WIDTH'(1));
        for (int i = 0; i < 5; i++) begin
            put(2'b11, 1'b0, 1);
            chk("sustain_valid", 32'(bus.result_valid), 1);
            chk("sustain_result", 32'(bus.result), 1);
        end
        bus.result_ack = 1'b1;
        put(2'b11, 1'b0, 1);
        bus.result_ack = 1'b0;
        chk("ack_drop_valid", 32'(bus.result_valid), 0);
        repeat (2) put(2'b11, 1'b0, 1);
        chk("no_recapture", 32'(bus.result_valid), 0);
        put(2'b00, 1'b0, 0);
        query(0, 0);
        query(1, 1);
        query(2, 0);
        query(3, 0);

        // Stepping through the sequence.
        step(2);
        query(2, 1);
        for (int n = 3; n <= 10; n++) step(n);
        query(10, 55);
        for (int n = 11; n <= 24; n++) step(n);
        query(24, 46368);
        chk("overflow_24", 32'(bus.overflow), 0);
        step(25);
        chk("overflow_25", 32'(bus.overflow), 1);
        query(25, 9489);
        repeat (3) put(2'b00, 1'b0, 0);
        chk("overflow_sticky", 32'(bus.overflow), 1);

        // number==0: write-zero at address 0 doubles as a result event.
        exp_q.push_back(WIDTH'(0));
        repeat (3) put(2'b11, 1'b1, 0);
        chk("zero_valid", 32'(bus.result_valid), 1);
        chk("zero_result", 32'(bus.result), 0);
        bus.result_ack = 1'b1;
        put(2'b00, 1'b0, 0);
        bus.result_ack = 1'b0;
        query(0, 0);

        // Delayed ack; a new event rise during the hold is dropped.
        exp_q.push_back(WIDTH'(55));
        put(2'b11, 1'b0, 10);
        for (int i = 0; i < 7; i++) begin
            if (i == 3) put(2'b11, 1'b0, 2);
            else        put(2'b00, 1'b0, 0);
            chk("hold_result", 32'(bus.result), 55);
            chk("hold_valid", 32'(bus.result_valid), 1);
        end
        bus.result_ack = 1'b1;
        put(2'b00, 1'b0, 0);
        bus.result_ack = 1'b0;
        chk("hold_released", 32'(bus.result_valid), 0);

        // Ack coincides with a new event rise.
        exp_q.push_back(WIDTH'(55));
        put(2'b11, 1'b0, 10);
        put(2'b00, 1'b0, 0);
        exp_q.push_back(WIDTH'(46368));
        bus.result_ack = 1'b1;
        put(2'b11, 1'b0, 24);
        chk("ack_cap_valid", 32'(bus.result_valid), 1);
        chk("ack_cap_result", 32'(bus.result), 46368);
        put(2'b00, 1'b0, 0);
        bus.result_ack = 1'b0;

        // Out-of-range accesses.
        put(2'b00, 1'b1, 100);
        chk("range_err_set", 32'(bus.range_err), 1);
        put(2'b00, 1'b1, 74);
        query(10, 55);
        query(100, 0);

        // Reset between operand B and the write, with a result held.
        put(2'b11, 1'b0, 10);
        put(2'b00, 1'b0, 0);
        put(2'b01, 1'b0, 23);
        put(2'b10, 1'b0, 24);
        reset = 1'b1;
        put(2'b11, 1'b1, 26);
        reset = 1'b0;
        put(2'b00, 1'b0, 0);
        chk("rst_mid_valid", 32'(bus.result_valid), 0);
        chk("rst_mid_result", 32'(bus.result), 0);
        chk("rst_mid_overflow", 32'(bus.overflow), 0);
        chk("rst_mid_range_err", 32'(bus.range_err), 0);
        query(24, 46368);
        query(25, 9489);
        put(2'b11, 1'b1, 26);
        chk("rst_ops_cleared_ovf", 32'(bus.overflow), 0);
        query(26, 0);

        repeat (2) put(2'b00, 1'b0, 0);
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
